wb_regfile: RTL and testbench
=============================

Name: wb_regfile

Overview:
- Writeback-side consumer of the MEM/WB pipeline register outputs.
- Selects the writeback value, either the ALU result or the load data, and commits it to a 32x64 integer register file.
- Serves two combinational read ports to the decode stage.
- Counts committed register writes for performance and debug observation.

Parameters:
- XLEN, 64, datapath width of registers, read ports and writeback data.
- NREGS, 32, number of architectural registers (addressed by 5 bits).
- CNT_W, 32, width of the writeback commit counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- wb_alu_out  input  XLEN  ALU result from MEM/WB.
- wb_mem_data  input  XLEN  load data from MEM/WB.
- wb_rd  input  5  destination register index from MEM/WB.
- wb_mem_to_reg  input  1  1 selects wb_mem_data; 0 selects wb_alu_out.
- wb_reg_write_en  input  1  commit enable from MEM/WB.
- rs1_addr  input  5  read port 1 index (decode stage).
- rs2_addr  input  5  read port 2 index (decode stage).
- rs1_data  output  XLEN  read port 1 data.
- rs2_data  output  XLEN  read port 2 data.
- wb_data  output  XLEN  selected writeback value, driven combinationally to forwarding logic.
- wb_commit  output  1  registered pulse, high one cycle after each effective write.
- commit_count  output  CNT_W  running count of effective writes.

Behaviour:
- Reset is asynchronous, active-high, from clk/reset as already decided. While reset is asserted:
  - all NREGS registers are 0;
  - wb_commit = 0;
  - commit_count = 0.
- Reset asserted mid-write aborts that write. The first write after deassertion is taken at the first rising edge with reset low.
- wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_out.
  - Purely combinational and independent of wb_reg_write_en.
- Effective write = wb_reg_write_en && (wb_rd != 0).
  - On the rising edge, regs[wb_rd] <= wb_data.
  - Writes to x0 are discarded; x0 always reads 0.
- Read ports are combinational with zero latency: rsN_data = (rsN_addr == 0) ? 0 : regs[rsN_addr].
  - Same-cycle write bypass is governed by the optional feature below.
- rs1_addr == rs2_addr is legal; both ports return identical data.
- wb_commit is registered: it equals the effective-write condition sampled at the previous edge.
- commit_count increments by 1 on each edge with an effective write.
  - It wraps modulo 2^CNT_W (all-ones + 1 -> 0); there is no saturation.
- Writes to x0 do not assert wb_commit and do not increment commit_count.
- X on wb_rd with wb_reg_write_en = 0 must not corrupt state.

Optional Feature:
- Macro: WB_REGFILE_BYPASS_EN.
- Defined: write-through bypass. If an effective write is pending this cycle and rsN_addr == wb_rd, then rsN_data = wb_data in the same cycle, before the edge. This removes the decode/writeback hazard.
- Undefined: read ports return the array contents only. A same-cycle read of wb_rd returns the old value; the new value is visible the cycle after the edge. The hazard unit must stall one cycle in this case.
- x0 reads return 0 in both builds.

Test Plan:
- Reset check: assert reset asynchronously between edges -> rs1_data, rs2_data, commit_count and wb_commit all 0 immediately; after release, reads of x1..x31 return 0.
- ALU writeback: wb_rd=5, wb_alu_out=64'h1234, wb_mem_to_reg=0, wb_reg_write_en=1 for one edge -> next cycle rs1_addr=5 reads 64'h1234, wb_commit=1 for one cycle, commit_count=1.
- Load writeback and x0: wb_rd=7, wb_mem_data=64'hDEAD_BEEF, wb_mem_to_reg=1 -> x7 = 64'hDEAD_BEEF. Then wb_rd=0 with data 64'hFF -> x0 reads 0, commit_count unchanged, no wb_commit pulse.
- Same-cycle hazard: x3 holds 64'h11; write 64'h22 to x3 while rs2_addr=3 -> rs2_data=64'h22 before the edge with WB_REGFILE_BYPASS_EN defined, 64'h11 without; 64'h22 after the edge in both builds.
- Dual port and disabled write: rs1_addr=rs2_addr=5 -> both 64'h1234. wb_reg_write_en=0, wb_rd=5, wb_alu_out=0 -> x5 unchanged, count unchanged.
- Counter wrap: with CNT_W=4, perform 17 effective writes -> commit_count=1. Assert reset mid-sequence -> commit_count=0 at once.

Source files
------------

// File: rtl/wb_regfile_if.sv
// Writeback/decode bus for wb_regfile: MEM/WB writeback inputs, the two decode
// read ports, and the commit observation outputs.
interface wb_regfile_if #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 32
);
  logic [XLEN-1:0]  wb_alu_out;
  logic [XLEN-1:0]  wb_mem_data;
  logic [4:0]       wb_rd;
  logic             wb_mem_to_reg;
  logic             wb_reg_write_en;
  logic [4:0]       rs1_addr;
  logic [4:0]       rs2_addr;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;
  logic [XLEN-1:0]  wb_data;
  logic             wb_commit;
  logic [CNT_W-1:0] commit_count;

  // The pipeline/decode side drives addresses and writeback values.
  modport master (
    output wb_alu_out, wb_mem_data, wb_rd, wb_mem_to_reg, wb_reg_write_en,
    output rs1_addr, rs2_addr,
    input  rs1_data, rs2_data, wb_data, wb_commit, commit_count
  );

  modport slave (
    input  wb_alu_out, wb_mem_data, wb_rd, wb_mem_to_reg, wb_reg_write_en,
    input  rs1_addr, rs2_addr,
    output rs1_data, rs2_data, wb_data, wb_commit, commit_count
  );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage register file: writeback mux, 32 x XLEN integer registers,
// two combinational read ports and a commit counter.
// Define WB_REGFILE_BYPASS_EN to forward a same-cycle write to the read ports.
module wb_regfile #(
  parameter int XLEN  = 64,
  parameter int NREGS = 32,
  parameter int CNT_W = 32
) (
  input  logic         clk,
  input  logic         reset,
  wb_regfile_if.slave  bus
);

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic             wb_commit_q;
  logic             wb_commit_d;
  logic [CNT_W-1:0] commit_count_q;
  logic [CNT_W-1:0] commit_count_d;

  logic [XLEN-1:0]  wb_data;
  logic             write_en;
  logic [XLEN-1:0]  rs1_data;
  logic [XLEN-1:0]  rs2_data;

  // The enable is tested first so an unknown wb_rd with the enable low stays inert.
  always_comb begin
    wb_data  = bus.wb_mem_to_reg ? bus.wb_mem_data : bus.wb_alu_out;
    write_en = 1'b0;
    if (bus.wb_reg_write_en) begin
      write_en = (bus.wb_rd != 5'd0);
    end
  end

  always_comb begin
    regs_d = regs_q;
    if (write_en) begin
      regs_d[bus.wb_rd] = wb_data;
    end
  end

  always_comb begin
    wb_commit_d    = write_en;
    commit_count_d = commit_count_q;
    if (write_en) begin
      commit_count_d = commit_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      wb_commit_q    <= 1'b0;
      commit_count_q <= '0;
    end else begin
      regs_q         <= regs_d;
      wb_commit_q    <= wb_commit_d;
      commit_count_q <= commit_count_d;
    end
  end

  // x0 is forced to zero at the port, never by relying on array contents.
  always_comb begin
    rs1_data = '0;
    rs2_data = '0;
    if (bus.rs1_addr != 5'd0) begin
      rs1_data = regs_q[bus.rs1_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (write_en && (bus.rs1_addr == bus.wb_rd)) begin
        rs1_data = wb_data;
      end
`endif
    end
    if (bus.rs2_addr != 5'd0) begin
      rs2_data = regs_q[bus.rs2_addr];
`ifdef WB_REGFILE_BYPASS_EN
      if (write_en && (bus.rs2_addr == bus.wb_rd)) begin
        rs2_data = wb_data;
      end
`endif
    end
  end

  assign bus.wb_data      = wb_data;
  assign bus.rs1_data     = rs1_data;
  assign bus.rs2_data     = rs2_data;
  assign bus.wb_commit    = wb_commit_q;
  assign bus.commit_count = commit_count_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a vector table for the writeback/read paths plus
// hand sequences for async reset, aborted writes and commit counter wrap.
module tb_wb_regfile;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int CNT_W = 4;

`ifdef WB_REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  wb_regfile_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  wb_regfile #(.XLEN(XLEN), .NREGS(NREGS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] alu;
    logic [63:0] mem;
    logic [4:0]  rd;
    logic        m2r;
    logic        we;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [63:0] exp_rs1;
    logic [63:0] exp_rs2;
    logic [63:0] exp_wb;
    logic        exp_commit;
    logic [3:0]  exp_count;
  } vec_t;

  vec_t vecs [9];

  task automatic applyStimulus(input logic [63:0] alu, input logic [63:0] mem,
                               input logic [4:0] rd, input logic m2r, input logic we,
                               input logic [4:0] rs1, input logic [4:0] rs2);
    bus.wb_alu_out      = alu;
    bus.wb_mem_data     = mem;
    bus.wb_rd           = rd;
    bus.wb_mem_to_reg   = m2r;
    bus.wb_reg_write_en = we;
    bus.rs1_addr        = rs1;
    bus.rs2_addr        = rs2;
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic doWrite(input logic [4:0] rd, input logic [63:0] data);
    @(negedge clk);
    applyStimulus(data, 64'h0, rd, 1'b0, 1'b1, 5'd0, 5'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Expected pre-edge reads reflect the state before each row's edge.
    vecs[0] = '{64'h1234, 64'h0, 5'd5, 1'b0, 1'b1, 5'd5, 5'd0,
                BYP ? 64'h1234 : 64'h0, 64'h0, 64'h1234, 1'b1, 4'd1};
    vecs[1] = '{64'h999, 64'hDEAD_BEEF, 5'd7, 1'b1, 1'b1, 5'd5, 5'd7,
                64'h1234, BYP ? 64'hDEAD_BEEF : 64'h0, 64'hDEAD_BEEF, 1'b1, 4'd2};
    vecs[2] = '{64'hFF, 64'h0, 5'd0, 1'b0, 1'b1, 5'd0, 5'd7,
                64'h0, 64'hDEAD_BEEF, 64'hFF, 1'b0, 4'd2};
    vecs[3] = '{64'h11, 64'h0, 5'd3, 1'b0, 1'b1, 5'd0, 5'd0,
                64'h0, 64'h0, 64'h11, 1'b1, 4'd3};
    vecs[4] = '{64'h22, 64'h0, 5'd3, 1'b0, 1'b1, 5'd7, 5'd3,
                64'hDEAD_BEEF, BYP ? 64'h22 : 64'h11, 64'h22, 1'b1, 4'd4};
    vecs[5] = '{64'h0, 64'h0, 5'd5, 1'b0, 1'b0, 5'd5, 5'd5,
                64'h1234, 64'h1234, 64'h0, 1'b0, 4'd4};
    vecs[6] = '{64'h5, 64'hAAAA, 5'd3, 1'b1, 1'b0, 5'd3, 5'd3,
                64'h22, 64'h22, 64'hAAAA, 1'b0, 4'd4};
    vecs[7] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 5'd31, 1'b0, 1'b1, 5'd31, 5'd3,
                BYP ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0, 64'h22,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 4'd5};
    vecs[8] = '{64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd31, 5'd5,
                64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h0, 1'b0, 4'd5};

    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd1, 5'd31);
    #2;
    checkOutput("reset_rs1", bus.rs1_data, 64'h0);
    checkOutput("reset_rs2", bus.rs2_data, 64'h0);
    checkOutput("reset_commit", 64'(bus.wb_commit), 64'h0);
    checkOutput("reset_count", 64'(bus.commit_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      applyStimulus(vecs[i].alu, vecs[i].mem, vecs[i].rd, vecs[i].m2r, vecs[i].we,
                    vecs[i].rs1, vecs[i].rs2);
      #1;
      checkOutput($sformatf("vec%0d_wb_data", i), bus.wb_data, vecs[i].exp_wb);
      checkOutput($sformatf("vec%0d_rs1_pre", i), bus.rs1_data, vecs[i].exp_rs1);
      checkOutput($sformatf("vec%0d_rs2_pre", i), bus.rs2_data, vecs[i].exp_rs2);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_commit", i), 64'(bus.wb_commit), 64'(vecs[i].exp_commit));
      checkOutput($sformatf("vec%0d_count", i), 64'(bus.commit_count), 64'(vecs[i].exp_count));
    end

    // Post-edge visibility of the hazard write in both builds.
    @(negedge clk);
    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd3, 5'd31);
    #1;
    checkOutput("x3_after_edge", bus.rs1_data, 64'h22);
    checkOutput("x31_after_edge", bus.rs2_data, 64'hFFFF_FFFF_FFFF_FFFF);

    // Asynchronous reset between edges while a commit pulse is high.
    doWrite(5'd2, 64'h5555);
    checkOutput("pre_reset_commit", 64'(bus.wb_commit), 64'h1);
    checkOutput("pre_reset_count", 64'(bus.commit_count), 64'h6);
    @(negedge clk);
    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd2, 5'd5);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_rst_count", 64'(bus.commit_count), 64'h0);
    checkOutput("async_rst_commit", 64'(bus.wb_commit), 64'h0);
    checkOutput("async_rst_x2", bus.rs1_data, 64'h0);
    checkOutput("async_rst_x5", bus.rs2_data, 64'h0);

    // A write presented during reset is dropped.
    applyStimulus(64'h99, 64'h0, 5'd9, 1'b0, 1'b1, 5'd0, 5'd0);
    @(posedge clk);
    #1;
    checkOutput("abort_count", 64'(bus.commit_count), 64'h0);
    checkOutput("abort_commit", 64'(bus.wb_commit), 64'h0);
    @(negedge clk);
    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd9, 5'd0);
    #1;
    checkOutput("abort_x9", bus.rs1_data, 64'h0);
    reset = 1'b0;
    for (int r = 1; r < NREGS; r++) begin
      bus.rs1_addr = 5'(r);
      bus.rs2_addr = 5'(NREGS - r);
      #1;
      checkOutput($sformatf("sweep_rs1_x%0d", r), bus.rs1_data, 64'h0);
      checkOutput($sformatf("sweep_rs2_x%0d", NREGS - r), bus.rs2_data, 64'h0);
    end

    // First write after deassertion lands on the next rising edge.
    @(negedge clk);
    applyStimulus(64'h77, 64'h0, 5'd9, 1'b0, 1'b1, 5'd9, 5'd0);
    #1;
    checkOutput("first_wr_pre", bus.rs1_data, BYP ? 64'h77 : 64'h0);
    @(posedge clk);
    #1;
    checkOutput("first_wr_x9", bus.rs1_data, 64'h77);
    checkOutput("first_wr_commit", 64'(bus.wb_commit), 64'h1);
    checkOutput("first_wr_count", 64'(bus.commit_count), 64'h1);

    // Unknown destination with the enable low must be harmless.
    @(negedge clk);
    applyStimulus(64'hBAD, 64'h0, 5'bxxxxx, 1'b0, 1'b0, 5'd9, 5'd0);
    @(posedge clk);
    #1;
    checkOutput("xrd_x9", bus.rs1_data, 64'h77);
    checkOutput("xrd_commit", 64'(bus.wb_commit), 64'h0);
    checkOutput("xrd_count", 64'(bus.commit_count), 64'h1);

    // Counter wrap at 4 bits: 17 writes from zero leave a count of 1.
    @(negedge clk);
    reset = 1'b1;
    #1;
    checkOutput("wrap_rst_count", 64'(bus.commit_count), 64'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      doWrite(5'((k % 31) + 1), 64'(k));
      if (k >= 15) begin
        checkOutput($sformatf("wrap_count_%0d", k), 64'(bus.commit_count), 64'(k % 16));
      end
    end
    for (int k = 0; k < 3; k++) begin
      doWrite(5'd4, 64'(k));
    end
    checkOutput("mid_seq_count", 64'(bus.commit_count), 64'h4);
    @(negedge clk);
    applyStimulus(64'h0, 64'h0, 5'd0, 1'b0, 1'b0, 5'd4, 5'd0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("mid_seq_rst_count", 64'(bus.commit_count), 64'h0);
    checkOutput("mid_seq_rst_x4", bus.rs1_data, 64'h0);
    @(negedge clk);
    reset = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
